twiddle_server: RTL and testbench
=================================

TWIDDLE_SERVER -- requirements
Module: twiddle_server

Interface
REQ-001 Parameter NUM_PORTS, default 8: number of parallel twiddle read lanes.
REQ-002 Parameter WIDTH_ADDR, default 8: width of each lane address.
REQ-003 Parameter WIDTH_DATA, default 12: width of each twiddle value.
REQ-004 Parameter DEPTH, default 128: number of valid table entries; DEPTH <= 2**WIDTH_ADDR.
REQ-005 Parameter Q, default 3329: modulus.
REQ-006 Port clk_i  in  1: single clock; all logic on posedge clk_i.
REQ-007 Port rst_i  in  1: reset, synchronous, active-low.
REQ-008 Port req_valid_i  in  1: request present.
REQ-009 Port req_ready_o  out  1: request accepted this cycle when high with req_valid_i.
REQ-010 Port mode_i  in  1: 0 = forward twiddle, 1 = inverse (negated) twiddle; sampled with the request.
REQ-011 Port addr_i  in  NUM_PORTS*WIDTH_ADDR: packed lane addresses, lane k at bits [k*WIDTH_ADDR +: WIDTH_ADDR].
REQ-012 Port resp_valid_o  out  1: response data valid.
REQ-013 Port resp_ready_i  in  1: downstream accepts response.
REQ-014 Port data_o  out  NUM_PORTS*WIDTH_DATA: packed lane twiddles, same lane packing as addr_i.
REQ-015 Port err_o  out  1: sticky out-of-range flag.
REQ-016 Port err_clr_i  in  1: clears err_o.

Function
REQ-017 Table SHALL be constant: entry i = 17^brv7(i) mod Q for i in 0..DEPTH-1 (zeta[0]=1, zeta[1]=1729, zeta[2]=2580, zeta[64]=17, zeta[127]=2154); not reloaded at reset.
REQ-018 Pipeline SHALL have two register stages: S1 = table read + mode/valid/range capture, S2 = conditional negation + output register.
REQ-019 Advance enable en = !resp_valid_o || resp_ready_i; both stages load only when en is high.
REQ-020 req_ready_o SHALL equal en (combinational); a request transfers when req_valid_i && req_ready_o.
REQ-021 With resp_ready_i held high, a request accepted at cycle N SHALL appear with resp_valid_o high at cycle N+2.
REQ-022 While resp_valid_o && !resp_ready_i, data_o and resp_valid_o SHALL hold stable; S1 holds; no request is accepted.
REQ-023 Bubbles are not collapsed: an empty S1 advances into S2 as resp_valid_o = 0.
REQ-024 Forward lane output = zeta[addr]; inverse lane output = Q - zeta[addr] (zeta never 0, result in 1..Q-1).
REQ-025 Lanes SHALL be independent; identical addresses on several lanes are legal and return identical values.
REQ-026 Lane address >= DEPTH: that lane outputs 0 regardless of mode, other lanes unaffected; err_o sets on the cycle the response with the bad lane becomes valid.
REQ-027 err_o stays set until err_clr_i sampled high; clear and new error in same cycle -> err_o = 1 (set wins).
REQ-028 Output values SHALL always be < Q, WIDTH_DATA bits wide, zero-extended if WIDTH_DATA exceeds needed width.

Reset
REQ-029 rst_i low at a clock edge: resp_valid_o = 0, S1 valid = 0, err_o = 0, data_o = 0 at that edge.
REQ-030 During reset req_ready_o SHALL read 1 (en high since resp_valid_o = 0) but no request is captured.
REQ-031 Reset mid-operation discards all in-flight requests; no response for them appears after reset release.
REQ-032 First request accepted on the first edge with rst_i high.

Verification
REQ-033 Forward burst: lanes addr 0..7, mode 0, resp_ready_i = 1 -> two cycles later data_o lanes = 1,1729,2580,3289,2642,630,1897,848.
REQ-034 Inverse: lane0 addr 1, lane1 addr 127, mode 1 -> lane0 = 1600, lane1 = 1175; back-to-back alternating modes each return correct per-request mode.
REQ-035 Backpressure: resp_ready_i low 3 cycles with full pipeline -> req_ready_o = 0, data_o stable, no loss/duplication after release, order preserved.
REQ-036 Out-of-range: lane3 addr 200, others valid -> lane3 = 0, others correct, err_o = 1 sticky; err_clr_i pulse -> err_o = 0 next cycle.
REQ-037 Reset mid-stream: rst_i low one cycle with two requests in flight -> resp_valid_o = 0, err_o = 0, no stale responses afterwards.
REQ-038 Random: all 128 addresses x both modes on every lane vs reference model, random req_valid_i/resp_ready_i, all outputs < 3329.

Source files
------------

// File: rtl/twiddle_server.sv
// Multi-lane twiddle-factor server: constant zeta table (17^brv7(i) mod Q) read by NUM_PORTS lanes
// through a two-stage valid/ready pipeline, with optional negation and a sticky out-of-range flag.
module twiddle_server #(
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned WIDTH_ADDR = 8,
  parameter int unsigned WIDTH_DATA = 12,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned Q          = 3329
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            mode_i,
  input  logic [NUM_PORTS*WIDTH_ADDR-1:0] addr_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [NUM_PORTS*WIDTH_DATA-1:0] data_o,
  output logic                            err_o,
  input  logic                            err_clr_i
);

  localparam int unsigned TblSize = 2 ** WIDTH_ADDR;
  localparam logic [WIDTH_DATA-1:0] QW = WIDTH_DATA'(Q);

  function automatic int unsigned brv7(input int unsigned i);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 7; b++) begin
      r[6-b] = i[b];
    end
    return r;
  endfunction

  // Square-and-multiply keeps elaboration-time evaluation to a handful of steps per entry.
  function automatic int unsigned zeta_val(input int unsigned i);
    int unsigned e, r, b;
    if (i >= DEPTH) return 0;
    e = brv7(i);
    r = 1;
    b = 17 % Q;
    for (int k = 0; k < 7; k++) begin
      if (e[k]) r = (r * b) % Q;
      b = (b * b) % Q;
    end
    return r;
  endfunction

  // Table spans the full address space; entries at or beyond DEPTH read as zero.
  logic [WIDTH_DATA-1:0] zeta_tbl [TblSize];

  for (genvar i = 0; i < TblSize; i++) begin : g_tbl
    localparam int unsigned Zeta = zeta_val(i);
    assign zeta_tbl[i] = WIDTH_DATA'(Zeta);
  end

  logic                            en;
  logic                            s1_valid_q;
  logic                            s1_mode_q;
  logic [NUM_PORTS-1:0]            s1_oor_q;
  logic [NUM_PORTS*WIDTH_DATA-1:0] s1_zeta_q;
  logic                            resp_valid_q;
  logic [NUM_PORTS*WIDTH_DATA-1:0] data_q;
  logic                            err_q;
  logic                            err_d;

  logic [NUM_PORTS-1:0]            rd_oor;
  logic [NUM_PORTS*WIDTH_DATA-1:0] rd_zeta;
  logic [NUM_PORTS*WIDTH_DATA-1:0] s2_data;

  assign en          = !resp_valid_q || resp_ready_i;
  assign req_ready_o = en;

  always_comb begin
    rd_oor  = '0;
    rd_zeta = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      rd_zeta[k*WIDTH_DATA +: WIDTH_DATA] = zeta_tbl[addr_i[k*WIDTH_ADDR +: WIDTH_ADDR]];
      rd_oor[k] = 32'(addr_i[k*WIDTH_ADDR +: WIDTH_ADDR]) >= DEPTH;
    end
  end

  always_comb begin
    s2_data = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (s1_oor_q[k]) begin
        s2_data[k*WIDTH_DATA +: WIDTH_DATA] = '0;
      end else if (s1_mode_q) begin
        s2_data[k*WIDTH_DATA +: WIDTH_DATA] = QW - s1_zeta_q[k*WIDTH_DATA +: WIDTH_DATA];
      end else begin
        s2_data[k*WIDTH_DATA +: WIDTH_DATA] = s1_zeta_q[k*WIDTH_DATA +: WIDTH_DATA];
      end
    end
  end

  // A new error set takes priority over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (en && s1_valid_q && (|s1_oor_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 1'b0;
      s1_oor_q     <= '0;
      s1_zeta_q    <= '0;
      resp_valid_q <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      if (en) begin
        s1_valid_q   <= req_valid_i;
        s1_mode_q    <= mode_i;
        s1_oor_q     <= rd_oor;
        s1_zeta_q    <= rd_zeta;
        resp_valid_q <= s1_valid_q;
        data_q       <= s2_data;
      end
      err_q <= err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign data_o       = data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_twiddle_server.sv
// Self-checking bench for twiddle_server: directed scenarios plus a randomized scoreboard run
// against an arithmetic reference of the zeta table.
module tb_twiddle_server;

  localparam int NP    = 8;
  localparam int WA    = 8;
  localparam int WD    = 12;
  localparam int DEPTH = 128;
  localparam int Q     = 3329;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic             mode_i;
  logic [NP*WA-1:0] addr_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [NP*WD-1:0] data_o;
  logic             err_o;
  logic             err_clr_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  twiddle_server #(
    .NUM_PORTS (NP),
    .WIDTH_ADDR(WA),
    .WIDTH_DATA(WD),
    .DEPTH     (DEPTH),
    .Q         (Q)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .mode_i      (mode_i),
    .addr_i      (addr_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .data_o      (data_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  // Reference: plain repeated multiplication by 17, bit-reversed exponent.
  function automatic int zeta_ref(input int i);
    int e, p;
    if (i >= DEPTH) return 0;
    e = 0;
    for (int b = 0; b < 7; b++) begin
      if (((i >> b) & 1) == 1) e += (1 << (6 - b));
    end
    p = 1;
    for (int k = 0; k < e; k++) p = (p * 17) % Q;
    return p;
  endfunction

  function automatic logic [NP*WD-1:0] model(input logic [NP*WA-1:0] a, input logic m);
    logic [NP*WD-1:0] r;
    int ad, z, v;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      ad = int'(a[k*WA +: WA]);
      z  = zeta_ref(ad);
      if (ad >= DEPTH) v = 0;
      else if (m) v = Q - z;
      else v = z;
      r[k*WD +: WD] = WD'(v);
    end
    return r;
  endfunction

  function automatic logic [NP*WA-1:0] rand_addrs();
    logic [NP*WA-1:0] a;
    for (int k = 0; k < NP; k++) a[k*WA +: WA] = WA'($urandom_range(0, DEPTH - 1));
    return a;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i       = 1'b0;
    req_valid_i = 1'b1;
    addr_i      = rand_addrs();
    tick();
    tick();
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", resp_valid_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err_o); end
    tests++; if (data_o !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", data_o); end
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_no_capture: got %b expected 0", resp_valid_o); end
    end
  endtask

  task automatic test_forward();
    int fwd_exp [8];
    logic [NP*WA-1:0] a;
    fwd_exp = '{1, 1729, 2580, 3289, 2642, 630, 1897, 848};
    for (int k = 0; k < NP; k++) a[k*WA +: WA] = WA'(k);
    rst_i = 1'b0; addr_i = a; mode_i = 1'b0; req_valid_i = 1'b1; resp_ready_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL fwd_early: got %b expected 0", resp_valid_o); end
    tick();
    tests++; if (resp_valid_o !== 1'b1) begin fails++; $display("FAIL fwd_valid: got %b expected 1", resp_valid_o); end
    for (int k = 0; k < NP; k++) begin
      tests++;
      if (data_o[k*WD +: WD] !== WD'(fwd_exp[k])) begin
        fails++; $display("FAIL fwd_lane%0d: got %0d expected %0d", k, data_o[k*WD +: WD], fwd_exp[k]);
      end
    end
    tests++; if (data_o !== model(a, 1'b0)) begin fails++; $display("FAIL fwd_model: got %h expected %h", data_o, model(a, 1'b0)); end
    tick();
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL fwd_bubble: got %b expected 0", resp_valid_o); end
  endtask

  task automatic test_inverse();
    logic [NP*WA-1:0] a;
    logic [NP*WA-1:0] seq [4];
    a = rand_addrs();
    a[0 +: WA] = 8'd1;
    a[WA +: WA] = 8'd127;
    addr_i = a; mode_i = 1'b1; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    tests++; if (resp_valid_o !== 1'b1) begin fails++; $display("FAIL inv_valid: got %b expected 1", resp_valid_o); end
    tests++; if (data_o[0 +: WD] !== 12'd1600) begin fails++; $display("FAIL inv_lane0: got %0d expected 1600", data_o[0 +: WD]); end
    tests++; if (data_o[WD +: WD] !== 12'd1175) begin fails++; $display("FAIL inv_lane1: got %0d expected 1175", data_o[WD +: WD]); end
    tests++; if (data_o !== model(a, 1'b1)) begin fails++; $display("FAIL inv_model: got %h expected %h", data_o, model(a, 1'b1)); end
    for (int i = 0; i < 4; i++) seq[i] = rand_addrs();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid_i = 1'b1; addr_i = seq[i]; mode_i = i[0];
      end else begin
        req_valid_i = 1'b0;
      end
      tick();
      if (i >= 1) begin
        tests++;
        if (resp_valid_o !== 1'b1 || data_o !== model(seq[i-1], i[0] ^ 1'b1)) begin
          fails++; $display("FAIL b2b_req%0d: got v=%b %h expected v=1 %h", i - 1, resp_valid_o, data_o,
                            model(seq[i-1], i[0] ^ 1'b1));
        end
      end
    end
    tick();
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b expected 0", resp_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [NP*WD-1:0] expq[$];
    logic [NP*WD-1:0] exp_d;
    logic [NP*WA-1:0] a;
    logic m;
    int accepted = 0;
    int responses = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      a = rand_addrs();
      m = 1'($urandom_range(0, 1));
      req_valid_i  = (cyc < 8);
      addr_i       = a;
      mode_i       = m;
      resp_ready_i = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        tests++;
        if (req_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready_c%0d: got %b expected 0", cyc, req_ready_o); end
        tests++;
        if (expq.size() == 0 || resp_valid_o !== 1'b1 || data_o !== expq[0]) begin
          fails++; $display("FAIL bp_hold_c%0d: got v=%b %h, queue %0d", cyc, resp_valid_o, data_o, expq.size());
        end
      end
      if (resp_valid_o && resp_ready_i) begin
        responses++;
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL bp_extra: got %h expected no response", data_o);
        end else begin
          exp_d = expq.pop_front();
          if (data_o !== exp_d) begin fails++; $display("FAIL bp_data: got %h expected %h", data_o, exp_d); end
        end
      end
      if (req_valid_i && req_ready_o) begin
        expq.push_back(model(a, m));
        accepted++;
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    tests++;
    if (accepted !== 5 || responses !== 5 || expq.size() != 0) begin
      fails++; $display("FAIL bp_count: got acc=%0d resp=%0d left=%0d expected 5 5 0", accepted, responses, expq.size());
    end
  endtask

  task automatic test_out_of_range();
    logic [NP*WA-1:0] a;
    logic m;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_pre: got %b expected 0", err_o); end
    a = rand_addrs();
    a[3*WA +: WA] = 8'd200;
    m = 1'($urandom_range(0, 1));
    addr_i = a; mode_i = m; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_early: got %b expected 0", err_o); end
    tick();
    tests++; if (resp_valid_o !== 1'b1 || data_o !== model(a, m)) begin
      fails++; $display("FAIL oor_data: got v=%b %h expected %h", resp_valid_o, data_o, model(a, m)); end
    tests++; if (data_o[3*WD +: WD] !== '0) begin fails++; $display("FAIL oor_lane3: got %0d expected 0", data_o[3*WD +: WD]); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_err_set: got %b expected 1", err_o); end
    tick();
    tick();
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_sticky: got %b expected 1", err_o); end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL oor_clear: got %b expected 0", err_o); end
    a = rand_addrs();
    a[5*WA +: WA] = WA'($urandom_range(DEPTH, 255));
    addr_i = a; mode_i = 1'b0; req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    err_clr_i   = 1'b1;
    tick();
    err_clr_i = 1'b0;
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_set_wins: got %b expected 1", err_o); end
    tick();
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL oor_set_hold: got %b expected 1", err_o); end
  endtask

  task automatic test_reset_midstream();
    req_valid_i = 1'b1; addr_i = rand_addrs(); mode_i = 1'b0;
    tick();
    addr_i = rand_addrs(); mode_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    rst_i       = 1'b0;
    tick();
    tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", resp_valid_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL mid_err: got %b expected 0", err_o); end
    tests++; if (data_o !== '0) begin fails++; $display("FAIL mid_data: got %h expected 0", data_o); end
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL mid_stale_c%0d: got %b expected 0", i, resp_valid_o); end
    end
  endtask

  task automatic test_random();
    logic [NP*WD-1:0] expq[$];
    logic [NP*WD-1:0] exp_d;
    logic [NP*WA-1:0] a;
    logic m;
    logic bad;
    int sent = 0;
    int cyc = 0;
    int base;
    base = int'($urandom_range(0, DEPTH - 1));
    while ((sent < 256 || expq.size() != 0) && cyc < 6000) begin
      for (int k = 0; k < NP; k++) a[k*WA +: WA] = WA'(((sent % DEPTH) + base + k * 37) % DEPTH);
      m = (sent >= DEPTH);
      req_valid_i  = (sent < 256) && ($urandom_range(0, 3) != 0);
      addr_i       = a;
      mode_i       = m;
      resp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (resp_valid_o && !resp_ready_i) begin
        tests++;
        if (req_ready_o !== 1'b0) begin fails++; $display("FAIL rnd_stall_ready: got %b expected 0", req_ready_o); end
      end
      if (resp_valid_o && resp_ready_i) begin
        tests++;
        if (expq.size() == 0) begin
          fails++; $display("FAIL rnd_extra: got %h expected no response", data_o);
        end else begin
          exp_d = expq.pop_front();
          if (data_o !== exp_d) begin fails++; $display("FAIL rnd_data: got %h expected %h", data_o, exp_d); end
        end
        bad = 1'b0;
        for (int k = 0; k < NP; k++) if (int'(data_o[k*WD +: WD]) >= Q) bad = 1'b1;
        tests++;
        if (bad) begin fails++; $display("FAIL rnd_range: got %h expected all lanes < %0d", data_o, Q); end
      end
      if (req_valid_i && req_ready_o) begin
        expq.push_back(model(a, m));
        sent++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    req_valid_i  = 1'b0;
    resp_ready_i = 1'b1;
    tests++;
    if (sent != 256 || expq.size() != 0) begin
      fails++; $display("FAIL rnd_timeout: got sent=%0d pending=%0d expected 256 0", sent, expq.size());
    end
  endtask

  initial begin
    rst_i = 1'b0; req_valid_i = 1'b0; mode_i = 1'b0; addr_i = '0;
    resp_ready_i = 1'b1; err_clr_i = 1'b0;
    test_reset();
    test_forward();
    test_inverse();
    test_backpressure();
    test_out_of_range();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
